// File: rtl/lnl_io_pkg.sv
// Shared constants and types for the LnL keyboard/display I/O port.
package lnl_io_pkg;

  localparam int unsigned LNL_IO_DEPTH_DEF    = 4;
  localparam int unsigned LNL_IO_OUT_HOLD_DEF = 8;
  localparam int unsigned LNL_IO_BYTE_W       = 8;

  localparam logic [LNL_IO_BYTE_W-1:0] LNL_IO_DISPLAY_RST = 8'h00;

  typedef logic [LNL_IO_BYTE_W-1:0] lnl_byte_t;

endpackage

// File: rtl/lnl_byte_fifo.sv
// Small byte FIFO with wrap-bit pointers; head byte reads as zero when empty.
module lnl_byte_fifo
  import lnl_io_pkg::*;
#(
  parameter int unsigned DEPTH = LNL_IO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [LNL_IO_BYTE_W-1:0] din,
  output logic [LNL_IO_BYTE_W-1:0] dout,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  lnl_byte_t   mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO is taken.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/lnl_io_port.sv
// Keyboard/display I/O port: strobe synchroniser, keyboard FIFO, OUTR/FGO
// busy timer and registered interrupt request for the LnL accumulator CPU.
module lnl_io_port
  import lnl_io_pkg::*;
#(
  parameter int unsigned DEPTH    = LNL_IO_DEPTH_DEF,
  parameter int unsigned OUT_HOLD = LNL_IO_OUT_HOLD_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LNL_IO_BYTE_W-1:0] kbd_data,
  input  logic                     kbd_strobe,
  input  logic                     cpu_inp,
  input  logic                     cpu_out,
  input  logic [LNL_IO_BYTE_W-1:0] cpu_out_data,
  input  logic                     ien,
  output logic [LNL_IO_BYTE_W-1:0] inpr,
  output logic                     fgi,
  output logic                     fgo,
  output logic                     overrun,
  output logic [LNL_IO_BYTE_W-1:0] display,
  output logic                     irq
);

  localparam int unsigned CW = (OUT_HOLD > 1) ? $clog2(OUT_HOLD) : 1;

  logic          sync0, sync1, sync_prev;
  logic [1:0]    warm;
  logic          armed;
  logic          kbd_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;

  logic          overrun_d;
  logic          fgo_d;
  logic [CW-1:0] cnt, cnt_d;
  lnl_byte_t     display_d;

  // Strobe synchroniser; armed only after a genuine low sample so a strobe
  // already high at reset release never counts as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0     <= 1'b0;
      sync1     <= 1'b0;
      sync_prev <= 1'b0;
      warm      <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sync0     <= kbd_strobe;
      sync1     <= sync0;
      sync_prev <= sync1;
      warm      <= {warm[0], 1'b1};
      armed     <= armed | (warm[1] & ~sync1);
    end
  end

  assign kbd_push = armed & sync1 & ~sync_prev;
  assign fifo_pop = cpu_inp & ~fifo_empty;
  assign fgi      = ~fifo_empty;

  lnl_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (kbd_push),
    .pop   (cpu_inp),
    .din   (kbd_data),
    .dout  (inpr),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state for overrun flag and the OUTR/FGO busy timer.
  always_comb begin
    overrun_d = overrun;
    fgo_d     = fgo;
    cnt_d     = cnt;
    display_d = display;
    if (fifo_pop) begin
      overrun_d = 1'b0;
    end else if (kbd_push && fifo_full) begin
      overrun_d = 1'b1;
    end
    if (cpu_out && fgo) begin
      display_d = cpu_out_data;
      fgo_d     = 1'b0;
      cnt_d     = CW'(OUT_HOLD - 1);
    end else if (!fgo) begin
      if (cnt == '0) fgo_d = 1'b1;
      else           cnt_d = cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
      fgo     <= 1'b1;
      cnt     <= '0;
      display <= LNL_IO_DISPLAY_RST;
      irq     <= 1'b0;
    end else begin
      overrun <= overrun_d;
      fgo     <= fgo_d;
      cnt     <= cnt_d;
      display <= display_d;
      irq     <= ien & (fgi | fgo);
    end
  end

endmodule

// File: tb/tb_lnl_io_port.sv
// Directed plus randomized bench for lnl_io_port against a queue-based model.
module tb_lnl_io_port;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned OUT_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] kbd_data;
  logic       kbd_strobe;
  logic       cpu_inp;
  logic       cpu_out;
  logic [7:0] cpu_out_data;
  logic       ien;
  logic [7:0] inpr;
  logic       fgi;
  logic       fgo;
  logic       overrun;
  logic [7:0] display;
  logic       irq;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  bit         m_ovr;

  lnl_io_port #(.DEPTH(DEPTH), .OUT_HOLD(OUT_HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .kbd_data     (kbd_data),
    .kbd_strobe   (kbd_strobe),
    .cpu_inp      (cpu_inp),
    .cpu_out      (cpu_out),
    .cpu_out_data (cpu_out_data),
    .ien          (ien),
    .inpr         (inpr),
    .fgi          (fgi),
    .fgo          (fgo),
    .overrun      (overrun),
    .display      (display),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_fifo(input string tag);
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'h00;
    chk({tag, "_fgi"}, 32'(fgi), 32'(q.size() != 0));
    chk({tag, "_inpr"}, 32'(inpr), 32'(head));
    chk({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
  endtask

  // Model: a strobe edge appends the byte unless the FIFO already holds DEPTH.
  task automatic model_push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic strobe_byte(input logic [7:0] b, input int hold);
    kbd_data = b;
    repeat (2) @(negedge clk);
    kbd_strobe = 1'b1;
    repeat (hold) @(negedge clk);
    kbd_strobe = 1'b0;
    repeat (4) @(negedge clk);
    model_push(b);
  endtask

  task automatic pop_one();
    cpu_inp = 1'b1;
    @(negedge clk);
    cpu_inp = 1'b0;
    if (q.size() != 0) begin
      void'(q.pop_front());
      m_ovr = 1'b0;
    end
  endtask

  task automatic wait_fgo(input string tag);
    int n = 0;
    while (!fgo && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(fgo), 32'd1);
  endtask

  // Issues an OUT and counts how many sampled cycles FGO stays low.
  task automatic out_and_count(input logic [7:0] d, input logic [7:0] d2, output int lows);
    cpu_out_data = d;
    cpu_out      = 1'b1;
    @(negedge clk);
    cpu_out = 1'b0;
    lows    = 0;
    while (!fgo && lows < 20) begin
      lows++;
      if (lows == 3) begin
        cpu_out      = 1'b1;
        cpu_out_data = d2;
      end else begin
        cpu_out = 1'b0;
      end
      @(negedge clk);
    end
    cpu_out = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] d;
    int         lat;
    int         lows;
    logic [7:0] seq3 [5];

    rst_n = 1'b0; kbd_data = 8'h00; kbd_strobe = 1'b0; cpu_inp = 1'b0;
    cpu_out = 1'b0; cpu_out_data = 8'h00; ien = 1'b0;
    m_ovr = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_display", 32'(display), 32'h00);
    chk("rst_fgo", 32'(fgo), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    check_fifo("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_fgo", 32'(fgo), 32'd1);
    chk("post_rst_irq", 32'(irq), 32'd0);
    check_fifo("post_rst");

    // Single long strobe: one push within three clocks of the rise
    kbd_data = 8'h77;
    @(negedge clk);
    kbd_strobe = 1'b1;
    lat = 0;
    while (!fgi && lat < 3) begin
      @(negedge clk);
      lat++;
    end
    chk("t2_latency_ok", 32'(fgi), 32'd1);
    repeat (45 - lat) @(negedge clk);
    kbd_strobe = 1'b0;
    repeat (4) @(negedge clk);
    model_push(8'h77);
    check_fifo("t2_held");
    pop_one();
    check_fifo("t2_popped");

    // Fill past DEPTH, then drain in order
    seq3[0] = 8'h11; seq3[1] = 8'h22; seq3[2] = 8'h33; seq3[3] = 8'h44; seq3[4] = 8'h55;
    for (int i = 0; i < 5; i++) begin
      strobe_byte(seq3[i], 3);
      check_fifo("t3_push");
    end
    for (int i = 0; i < 4; i++) begin
      chk("t3_head", 32'(inpr), 32'(seq3[i]));
      pop_one();
      check_fifo("t3_pop");
    end
    pop_one();
    check_fifo("t3_pop_empty");

    // Full FIFO with strobe edge coincident with cpu_inp
    for (int i = 0; i < 5; i++) begin
      strobe_byte(8'($urandom), 2);
    end
    check_fifo("t4_full");
    b = 8'($urandom);
    kbd_data = b;
    @(negedge clk);
    kbd_strobe = 1'b1;
    repeat (2) @(negedge clk);
    cpu_inp = 1'b1;
    @(negedge clk);
    cpu_inp = 1'b0;
    void'(q.pop_front());
    q.push_back(b);
    m_ovr = 1'b0;
    check_fifo("t4_coincide");
    repeat (2) @(negedge clk);
    kbd_strobe = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      pop_one();
      check_fifo("t4_drain");
    end

    // Randomized push/pop mix against the queue model
    repeat (40) begin
      if ($urandom_range(0, 2) != 2) strobe_byte(8'($urandom), int'($urandom_range(2, 6)));
      else pop_one();
      check_fifo("rand");
    end
    while (q.size() != 0) pop_one();
    check_fifo("rand_drained");

    // OUT timing and ignored OUT while busy
    out_and_count(8'h66, 8'hAA, lows);
    chk("t5_low_cycles", 32'(lows), 32'(OUT_HOLD));
    chk("t5_display", 32'(display), 32'h66);
    repeat (3) begin
      d = 8'($urandom);
      out_and_count(d, ~d, lows);
      chk("rand_out_low", 32'(lows), 32'(OUT_HOLD));
      chk("rand_out_disp", 32'(display), 32'(d));
    end

    // Interrupt request
    chk("t6_irq_idle", 32'(irq), 32'd0);
    ien = 1'b1;
    @(negedge clk);
    chk("t6_irq_on", 32'(irq), 32'd1);
    ien = 1'b0;
    @(negedge clk);
    chk("t6_irq_off", 32'(irq), 32'd0);
    ien = 1'b1;
    cpu_out_data = 8'h5A;
    cpu_out = 1'b1;
    @(negedge clk);
    cpu_out = 1'b0;
    chk("t6_irq_prev_fgo", 32'(irq), 32'd1);
    @(negedge clk);
    chk("t6_irq_busy", 32'(irq), 32'd0);
    ien = 1'b0;
    wait_fgo("t6_fgo_back");

    // Reset in the middle of a busy count, with data queued
    b = 8'($urandom);
    strobe_byte(b, 2);
    check_fifo("t6_pre_rst");
    ien = 1'b1;
    cpu_out_data = 8'hC3;
    cpu_out = 1'b1;
    @(negedge clk);
    cpu_out = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_irq_fgi", 32'(irq), 32'd1);
    chk("t6_busy", 32'(fgo), 32'd0);
    kbd_strobe = 1'b1;
    #2;
    rst_n = 1'b0;
    ien = 1'b0;
    #1;
    q.delete();
    m_ovr = 1'b0;
    chk("t6_rst_fgo", 32'(fgo), 32'd1);
    chk("t6_rst_display", 32'(display), 32'h00);
    chk("t6_rst_irq", 32'(irq), 32'd0);
    check_fifo("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_fifo("t6_held_strobe");
    kbd_strobe = 1'b0;
    repeat (4) @(negedge clk);
    b = 8'($urandom);
    kbd_data = b;
    kbd_strobe = 1'b1;
    repeat (5) @(negedge clk);
    q.push_back(b);
    check_fifo("t6_rearmed");
    kbd_strobe = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
